// File: rtl/game_pkg.sv
// Shared types and constants for the two-player LED ping-pong game controller.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_FLY   = 3'd2,
        ST_SCORE = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    localparam logic [3:0] LED_CTRL_SCORE = 4'b1000;
    localparam logic [3:0] LED_CTRL_SERVE = 4'b0100;
    localparam logic [3:0] LED_CTRL_BALL  = 4'b0010;
    localparam logic [3:0] LED_CTRL_BLINK = 4'b0001;
    localparam logic [3:0] LED_CTRL_OFF   = 4'b0000;

    localparam logic [5:0] BALL_LEFT  = 6'b000001;
    localparam logic [5:0] BALL_RIGHT = 6'b100000;
    localparam logic [5:0] BALL_NONE  = 6'b000000;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    function automatic logic [3:0] led_for(input state_t st);
        case (st)
            ST_SERVE: led_for = LED_CTRL_SERVE;
            ST_FLY:   led_for = LED_CTRL_BALL;
            ST_SCORE: led_for = LED_CTRL_SCORE;
            ST_OVER:  led_for = LED_CTRL_BLINK;
            default:  led_for = LED_CTRL_OFF;
        endcase
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Game tick generator: counts 0..TICK_DIV and pulses tick on the last count.
module tick_gen #(
    parameter int TICK_DIV = 24_999_999
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam int CNT_W = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(TICK_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CNT_TOP);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/game_ctrl.sv
// Ping-pong game controller: serve, ball flight with hit windows, scoring and game over.
module game_ctrl
    import game_pkg::*;
#(
    parameter int TICK_DIV    = 24_999_999,
    parameter int SCORE_TICKS = 4,
    parameter int WIN_POINTS  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       btn_l,
    input  logic       btn_r,
    output logic       right,
    output logic [3:0] score,
    output logic [5:0] s,
    output logic [3:0] led_control
);
    localparam int SC_W = (SCORE_TICKS > 1) ? $clog2(SCORE_TICKS) : 1;
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCORE_TICKS - 1);
    localparam logic [1:0] WIN = 2'(WIN_POINTS);

    state_t          state_q, state_d;
    logic            right_q, right_d;
    logic [3:0]      score_q, score_d;
    logic [5:0]      s_q, s_d;
    logic [3:0]      led_q, led_d;
    logic            dir_q, dir_d;
    logic [SC_W-1:0] sc_cnt_q, sc_cnt_d;

    logic tick;
    logic tick_clr;
    logic in_window;
    logic hit;

    function automatic logic [1:0] sat_inc(input logic [1:0] pts);
        sat_inc = (pts < WIN) ? pts + 2'd1 : pts;
    endfunction

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (tick_clr),
        .tick (tick)
    );

    // The receiver is whoever the ball is travelling toward; only their end is a window.
    assign in_window = (dir_q == DIR_LEFT) ? s_q[0] : s_q[5];
    assign hit       = (dir_q == DIR_LEFT) ? btn_l : btn_r;

    always_comb begin
        state_d  = state_q;
        right_d  = right_q;
        score_d  = score_q;
        s_d      = s_q;
        dir_d    = dir_q;
        sc_cnt_d = sc_cnt_q;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    score_d = 4'b0000;
                    right_d = 1'b1;
                    state_d = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (right_q && btn_r) begin
                    s_d     = BALL_RIGHT;
                    dir_d   = DIR_LEFT;
                    state_d = ST_FLY;
                end else if (!right_q && btn_l) begin
                    s_d     = BALL_LEFT;
                    dir_d   = DIR_RIGHT;
                    state_d = ST_FLY;
                end
            end
            ST_FLY: begin
                if (in_window && hit) begin
                    // Ball stays at the end until the next tick, then leaves.
                    dir_d = ~dir_q;
                end else if (tick) begin
                    if (in_window) begin
                        if (dir_q == DIR_LEFT) begin
                            score_d[1:0] = sat_inc(score_q[1:0]);
                            right_d      = 1'b1;
                        end else begin
                            score_d[3:2] = sat_inc(score_q[3:2]);
                            right_d      = 1'b0;
                        end
                        s_d      = BALL_NONE;
                        sc_cnt_d = '0;
                        state_d  = ST_SCORE;
                    end else if (dir_q == DIR_LEFT) begin
                        s_d = s_q >> 1;
                    end else begin
                        s_d = s_q << 1;
                    end
                end
            end
            ST_SCORE: begin
                if (tick) begin
                    if (sc_cnt_q == SC_LAST) begin
                        state_d = (score_q[3:2] == WIN || score_q[1:0] == WIN) ? ST_OVER : ST_SERVE;
                    end else begin
                        sc_cnt_d = sc_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        led_d    = led_for(state_d);
        tick_clr = (state_d != state_q) && (state_d == ST_FLY || state_d == ST_SCORE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            right_q  <= 1'b1;
            score_q  <= 4'b0000;
            s_q      <= BALL_NONE;
            led_q    <= LED_CTRL_OFF;
            dir_q    <= DIR_LEFT;
            sc_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            right_q  <= right_d;
            score_q  <= score_d;
            s_q      <= s_d;
            led_q    <= led_d;
            dir_q    <= dir_d;
            sc_cnt_q <= sc_cnt_d;
        end
    end

    assign right       = right_q;
    assign score       = score_q;
    assign s           = s_q;
    assign led_control = led_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with a 4-cycle tick and a 2-tick score display.
module tb_game_ctrl;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic       btn_l;
    logic       btn_r;
    logic       right;
    logic [3:0] score;
    logic [5:0] s;
    logic [3:0] led_control;

    int n_checks;
    int n_fail;

    game_ctrl #(
        .TICK_DIV   (3),
        .SCORE_TICKS(2),
        .WIN_POINTS (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .btn_l      (btn_l),
        .btn_r      (btn_r),
        .right      (right),
        .score      (score),
        .s          (s),
        .led_control(led_control)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        btn_l    = 1'b0;
        btn_r    = 1'b0;

        cyc(2);
        check_eq("rst_led", {4'b0, led_control}, 8'b0000_0000);
        check_eq("rst_s", {2'b0, s}, 8'b0000_0000);
        check_eq("rst_right", {7'b0, right}, 8'd1);
        check_eq("rst_score", {4'b0, score}, 8'b0000_0000);
        rst_n = 1'b1;
        cyc(1);
        check_eq("idle_led", {4'b0, led_control}, 8'b0000_0000);

        // Start a game
        start = 1'b1; cyc(1); start = 1'b0;
        check_eq("serve_led", {4'b0, led_control}, 8'b0000_0100);
        check_eq("serve_right", {7'b0, right}, 8'd1);
        check_eq("serve_score", {4'b0, score}, 8'b0000_0000);

        // Right serves
        btn_r = 1'b1; cyc(1); btn_r = 1'b0;
        check_eq("fly_s0", {2'b0, s}, 8'b0010_0000);
        check_eq("fly_led", {4'b0, led_control}, 8'b0000_0010);
        cyc(4);
        check_eq("fly_s1", {2'b0, s}, 8'b0001_0000);
        cyc(16);
        check_eq("fly_s5", {2'b0, s}, 8'b0000_0001);

        // Left hits back; ball holds, then moves away on the tick
        btn_l = 1'b1; cyc(1); btn_l = 1'b0;
        check_eq("hit_hold", {2'b0, s}, 8'b0000_0001);
        cyc(3);
        check_eq("hit_away", {2'b0, s}, 8'b0000_0010);

        // Right hit coincident with tick; start ignored in FLY
        cyc(16);
        check_eq("at_right", {2'b0, s}, 8'b0010_0000);
        cyc(3);
        btn_r = 1'b1; start = 1'b1; cyc(1); btn_r = 1'b0; start = 1'b0;
        check_eq("tickhit_s", {2'b0, s}, 8'b0010_0000);
        check_eq("tickhit_led", {4'b0, led_control}, 8'b0000_0010);
        cyc(4);
        check_eq("tickhit_away", {2'b0, s}, 8'b0001_0000);
        cyc(16);

        // Both buttons while left receives: rally continues
        btn_l = 1'b1; btn_r = 1'b1; cyc(1); btn_l = 1'b0; btn_r = 1'b0;
        cyc(3);
        check_eq("both_btn", {2'b0, s}, 8'b0000_0010);
        cyc(16);
        btn_r = 1'b1; cyc(1); btn_r = 1'b0;
        cyc(3);
        check_eq("ret_left", {2'b0, s}, 8'b0001_0000);
        cyc(16);

        // Only the non-receiver presses: left misses, right scores
        btn_r = 1'b1; cyc(1); btn_r = 1'b0;
        cyc(3);
        check_eq("pt1_score", {4'b0, score}, 8'b0000_0001);
        check_eq("pt1_right", {7'b0, right}, 8'd1);
        check_eq("pt1_led", {4'b0, led_control}, 8'b0000_1000);
        check_eq("pt1_s", {2'b0, s}, 8'b0000_0000);
        cyc(4);
        check_eq("pt1_hold", {4'b0, led_control}, 8'b0000_1000);
        cyc(4);
        check_eq("pt1_serve", {4'b0, led_control}, 8'b0000_0100);

        // Wrong server button ignored, then second point
        btn_l = 1'b1; cyc(1); btn_l = 1'b0;
        check_eq("wrong_srv", {4'b0, led_control}, 8'b0000_0100);
        btn_r = 1'b1; cyc(1); btn_r = 1'b0;
        cyc(20);
        check_eq("pt2_at_left", {2'b0, s}, 8'b0000_0001);
        cyc(4);
        check_eq("pt2_score", {4'b0, score}, 8'b0000_0010);
        cyc(8);
        check_eq("pt2_serve", {4'b0, led_control}, 8'b0000_0100);

        // Third point ends the game
        btn_r = 1'b1; cyc(1); btn_r = 1'b0;
        cyc(24);
        check_eq("pt3_score", {4'b0, score}, 8'b0000_0011);
        check_eq("pt3_led", {4'b0, led_control}, 8'b0000_1000);
        cyc(8);
        check_eq("over_led", {4'b0, led_control}, 8'b0000_0001);
        check_eq("over_score", {4'b0, score}, 8'b0000_0011);
        btn_r = 1'b1; cyc(1); btn_r = 1'b0;
        check_eq("over_btn", {4'b0, led_control}, 8'b0000_0001);

        // Restart from OVER
        start = 1'b1; cyc(1); start = 1'b0;
        check_eq("restart_score", {4'b0, score}, 8'b0000_0000);
        check_eq("restart_led", {4'b0, led_control}, 8'b0000_0100);
        check_eq("restart_right", {7'b0, right}, 8'd1);

        // Reset mid-rally
        btn_r = 1'b1; cyc(1); btn_r = 1'b0;
        cyc(6);
        check_eq("mid_s", {2'b0, s}, 8'b0001_0000);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_led", {4'b0, led_control}, 8'b0000_0000);
        check_eq("mid_rst_s", {2'b0, s}, 8'b0000_0000);
        check_eq("mid_rst_right", {7'b0, right}, 8'd1);
        check_eq("mid_rst_score", {4'b0, score}, 8'b0000_0000);
        cyc(1);
        rst_n = 1'b1;
        btn_r = 1'b1; cyc(1); btn_r = 1'b0;
        cyc(2);
        check_eq("post_rst_led", {4'b0, led_control}, 8'b0000_0000);
        check_eq("post_rst_s", {2'b0, s}, 8'b0000_0000);
        start = 1'b1; cyc(1); start = 1'b0;
        check_eq("post_rst_serve", {4'b0, led_control}, 8'b0000_0100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 24_999_999, clk cycles per game tick minus one (0.5 s at 50 MHz).
REQ-002 SHALL have parameter SCORE_TICKS, default 4, ticks the score is shown after each point.
REQ-003 SHALL have parameter WIN_POINTS, default 3, points that end a game (at most 3).
REQ-004 SHALL use one clock and an asynchronous active-low reset. Ports:
  clk          in   1  system clock, rising edge
  rst_n        in   1  asynchronous active-low reset
  start        in   1  one-cycle pulse, begins a game
  btn_l        in   1  one-cycle pulse, left player hit/serve
  btn_r        in   1  one-cycle pulse, right player hit/serve
  right        out  1  serve right: 1 = right player serves, 0 = left
  score        out  4  {left points[1:0], right points[1:0]}
  s            out  6  one-hot ball position; s[0] = left end, s[5] = right end
  led_control  out  4  display mode: 1000 score, 0100 serve, 0010 ball, 0001 blink, 0000 off

Function
REQ-005 SHALL implement states IDLE, SERVE, FLY, SCORE, OVER.
REQ-006 SHALL register all outputs; every output SHALL reflect a state change on the clk edge that causes it.
REQ-007 IDLE: led_control=0000, s=0. A start pulse SHALL clear score, set right=1 and go to SERVE.
REQ-008 SERVE: led_control=0100. Only the server's button (btn_r if right=1, else btn_l) SHALL be accepted. It loads s=100000 (right) or 000001 (left), direction toward the opponent, and goes to FLY.
REQ-009 FLY: led_control=0010. On each tick, s SHALL shift one position in the current direction.
REQ-010 Hit window: s is at the receiving end (s[0] when moving left, s[5] when moving right). The receiver's button in the window SHALL reverse direction. s stays at that end until the next tick, then moves away.
REQ-011 A button outside its own hit window, or the non-receiver's button, SHALL be ignored; no early-press penalty applies.
REQ-012 A tick while in the hit window with no hit SHALL award the point to the opponent of the receiver and go to SCORE.
REQ-013 If a hit and a tick fall on the same cycle, the hit SHALL take priority. If btn_l and btn_r fall on the same cycle, only the receiver's button counts.
REQ-014 SCORE: led_control=1000, s=0, right = the point winner. After SCORE_TICKS ticks, go to OVER if either count equals WIN_POINTS, else SERVE.
REQ-015 OVER: led_control=0001, score held. A start pulse SHALL act as in REQ-007.
REQ-016 Point counts SHALL saturate at WIN_POINTS and never wrap.
REQ-017 Tick counter: counts 0..TICK_DIV and pulses at TICK_DIV. It SHALL restart at 0 on entry to FLY and to SCORE.
REQ-018 start in SERVE, FLY or SCORE SHALL be ignored.

Reset
REQ-019 While rst_n=0, the block SHALL be in IDLE with right=1, score=0000, s=000000, led_control=0000, tick counter=0 and direction=left.
REQ-020 Reset asserted mid-rally SHALL abandon the rally; after release the block waits for start.

Structure
REQ-021 Package game_pkg SHALL hold the state enum, the LED_CTRL_{SCORE,SERVE,BALL,BLINK,OFF} constants and the ball end positions.
REQ-022 Sub-module tick_gen(clk, rst_n, clr, tick), parameterised by TICK_DIV, SHALL provide the tick.

Verification (TICK_DIV=3, SCORE_TICKS=2)
REQ-023 Reset then start -> SERVE, led_control=0100, right=1, score=0000.
REQ-024 btn_r in SERVE -> s=100000, led_control=0010. s reaches 000001 after 5 ticks. btn_l there -> s=000010 on the next tick.
REQ-025 No btn_l at s=000001 -> tick gives SCORE, score=0001, right=1. After 2 ticks -> SERVE.
REQ-026 btn_l and btn_r together with s=000001 moving left -> rally continues. btn_l coincident with the tick -> hit accepted.
REQ-027 Right wins 3 points -> score=0011, then OVER with led_control=0001. start -> score=0000, SERVE.
REQ-028 rst_n low mid-FLY -> all outputs at reset values immediately, IDLE after release.
